packet_arbiter: RTL and testbench
=================================

Name: packet_arbiter

Overview:
- Round-robin, packet-locked arbiter directly upstream of the output priority mux of the OPM stage.
- Selects one of DIMENSION upstream ports and drives the one-hot PacketEnable_dw_o vector that steers the mux.
- Holds the grant from the head flit to the tail flit and gates the valid/ready handshake between the chosen port and the downstream consumer.

Parameters:
- DIMENSION, 4, number of upstream ports (>=1).
- MAXLEN, 16, maximum flits per packet before a forced release (>=2).

Ports:
- Clk_i  in  1  clock, all state on rising edge.
- Rst_n_i  in  1  asynchronous active-low reset.
- Valid_up_i  in  DIMENSION  per-port flit valid.
- Tail_up_i  in  DIMENSION  per-port tail-flit marker; sampled only with a transfer.
- Ack_up_o  out  DIMENSION  per-port flit accepted (ready back to source).
- PacketEnable_dw_o  out  DIMENSION  registered one-hot grant to the mux; all-zero when idle.
- Sel_dw_o  out  max(1,$clog2(DIMENSION))  binary index of the granted port.
- Valid_dw_o  out  1  flit valid toward downstream.
- Ready_dw_i  in  1  downstream ready.
- Error_o  out  1  sticky flag: a packet was forcibly released at MAXLEN.

Behaviour:
- Reset (async assert, sync-safe deassert by design):
  - State=IDLE; Grant=0, so PacketEnable_dw_o=0.
  - Sel_dw_o=0, Pointer=0, FlitCnt=0, Error_o=0.
  - Ack_up_o=0, Valid_dw_o=0.
- Reset asserted mid-packet clears everything immediately. The packet in flight is abandoned; no transfer occurs on the reset edge.
- State IDLE:
  - Outputs: PacketEnable_dw_o=0, Valid_dw_o=0, Ack_up_o=0.
  - If any Valid_up_i is set: pick the first set bit scanning Pointer, Pointer+1, ..., wrapping mod DIMENSION.
  - Register Grant (one-hot) and Sel, then go to LOCKED.
  - Arbitration latency is exactly 1 cycle from valid seen to PacketEnable_dw_o asserted.
- State LOCKED, with g = Sel_dw_o:
  - Outputs: PacketEnable_dw_o=Grant; Valid_dw_o=Valid_up_i[g]; Ack_up_o[g]=Valid_up_i[g] & Ready_dw_i; all other Ack bits 0.
  - Transfer = Valid_up_i[g] & Ready_dw_i.
  - On each transfer FlitCnt increments.
  - Transfer with Tail_up_i[g]=1: Pointer<=(g+1) mod DIMENSION, FlitCnt<=0, go to IDLE.
  - Transfer with Tail=0 and FlitCnt==MAXLEN-1: forced release. Same actions as a tail transfer, plus Error_o<=1.
  - No transfer: hold everything, regardless of other ports' valids.
  - Valid_up_i[g] dropping mid-packet is legal; the grant is held.
- Each packet has one mandatory bubble cycle (IDLE) between packets. Maximum throughput is one flit per cycle within a packet.
- Single-flit packet (head=tail) gives LOCKED for exactly one cycle if Ready_dw_i=1.
- Simultaneous requests are resolved only by Pointer. No starvation: every requester is served within DIMENSION packets.
- DIMENSION=1: Pointer is constant 0; Sel_dw_o is 1 bit, tied 0.
- PacketEnable_dw_o is guaranteed one-hot or zero, so the downstream mux priority never matters.
- Error_o clears only on reset.

Decomposition:
- Shared OPM package:
  - State enum {IDLE, LOCKED}.
  - Index-width localparam function (max(1,clog2)).
- Sub-module rr_priority_select (combinational):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, binary index, any_req.
  - Implemented by double-width rotate-and-priority-encode.
- The top level holds the FSM, Pointer, FlitCnt and Error.

Test Plan:
- Reset, then Valid_up_i=4'b0100 with Ready=1 and a 3-flit packet (tail on 3rd) -> PacketEnable_dw_o=4'b0100 one cycle after valid; Ack_up_o[2] for 3 cycles; IDLE next; Pointer=3.
- All four valid continuously, 1-flit packets -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Backpressure: port 1 granted, Ready_dw_i low for 5 cycles -> Ack_up_o=0; PacketEnable_dw_o holds 4'b0010; port 3 valid is ignored; on Ready high, transfer resumes.
- Port 0 sends 16 flits with no tail, MAXLEN=16 -> release after the 16th transfer; Error_o=1 and sticky; next grant goes to port 1 if it is valid.
- Rst_n_i pulsed low mid-packet on port 2 -> PacketEnable_dw_o=0 and Error_o=0 immediately; after release, arbitration restarts from port 0.
- DIMENSION=1 build: a continuous stream of 2-flit packets -> alternating LOCKED(2 cycles)/IDLE(1 cycle); Sel_dw_o=0 throughout.

Source files
------------

// File: rtl/packet_arbiter_pkg.sv
// Shared definitions for the OPM-stage packet arbiter: FSM state codes and
// the index-width helper used to size binary port/count fields.
package packet_arbiter_pkg;

  typedef logic [0:0] arbState_t;

  localparam arbState_t IDLE   = 1'b0;
  localparam arbState_t LOCKED = 1'b1;

  // Width of a binary index over n items, never narrower than one bit.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/packet_arbiter_rr_priority_select.sv
// Combinational round-robin selector: first set request at or after the
// pointer, wrapping. Rotates a doubled request vector so a plain
// lowest-bit priority encoder does the circular search.
module packet_arbiter_rr_priority_select
  import packet_arbiter_pkg::*;
#(
  parameter int unsigned DIMENSION = 4,
  localparam int unsigned IdxW = idxWidth(DIMENSION)
) (
  input  logic [DIMENSION-1:0] req,
  input  logic [IdxW-1:0]      ptr,
  output logic [DIMENSION-1:0] grant,
  output logic [IdxW-1:0]      idx,
  output logic                 anyReq
);

  localparam logic [IdxW:0] DimWide = (IdxW+1)'(DIMENSION);

  logic [2*DIMENSION-1:0] doubled;
  logic [DIMENSION-1:0]   rotated;
  logic [IdxW-1:0]        offset;
  logic [IdxW:0]          sum;

  // Rotate, priority-encode, then map the offset back to an absolute port.
  always_comb begin
    doubled = {req, req};
    rotated = DIMENSION'(doubled >> ptr);
    offset  = '0;
    for (int i = DIMENSION - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IdxW'(i);
    end
    anyReq = |req;
    sum    = {1'b0, ptr} + {1'b0, offset};
    if (sum >= DimWide) sum = sum - DimWide;
    idx   = sum[IdxW-1:0];
    grant = '0;
    if (anyReq) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/packet_arbiter.sv
// Round-robin, packet-locked arbiter feeding the OPM output priority mux.
// A port is granted from its head flit through its tail flit (or until
// MAXLEN flits force a release); one IDLE bubble separates packets.
module packet_arbiter
  import packet_arbiter_pkg::*;
#(
  parameter int unsigned DIMENSION = 4,
  parameter int unsigned MAXLEN    = 16,
  localparam int unsigned IdxW = idxWidth(DIMENSION)
) (
  input  logic                 Clk_i,
  input  logic                 Rst_n_i,
  input  logic [DIMENSION-1:0] Valid_up_i,
  input  logic [DIMENSION-1:0] Tail_up_i,
  output logic [DIMENSION-1:0] Ack_up_o,
  output logic [DIMENSION-1:0] PacketEnable_dw_o,
  output logic [IdxW-1:0]      Sel_dw_o,
  output logic                 Valid_dw_o,
  input  logic                 Ready_dw_i,
  output logic                 Error_o
);

  localparam int unsigned    CntW    = idxWidth(MAXLEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAXLEN - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIMENSION - 1);

  arbState_t            stateQ, stateD;
  logic [DIMENSION-1:0] grantQ, grantD;
  logic [IdxW-1:0]      selQ, selD;
  logic [IdxW-1:0]      ptrQ, ptrD;
  logic [CntW-1:0]      cntQ, cntD;
  logic                 errQ, errD;

  logic [DIMENSION-1:0] rrGrant;
  logic [IdxW-1:0]      rrIdx;
  logic                 rrAny;

  logic locked;
  logic selValid;
  logic selTail;
  logic xfer;

  packet_arbiter_rr_priority_select #(
    .DIMENSION (DIMENSION)
  ) uSelect (
    .req    (Valid_up_i),
    .ptr    (ptrQ),
    .grant  (rrGrant),
    .idx    (rrIdx),
    .anyReq (rrAny)
  );

  // Handshake gating: only the locked port sees ready, only it drives valid.
  always_comb begin
    locked            = (stateQ == LOCKED);
    selValid          = Valid_up_i[selQ];
    selTail           = Tail_up_i[selQ];
    xfer              = locked & selValid & Ready_dw_i;
    PacketEnable_dw_o = grantQ;
    Sel_dw_o          = selQ;
    Valid_dw_o        = locked & selValid;
    Ack_up_o          = xfer ? grantQ : '0;
    Error_o           = errQ;
  end

  // Arbitrate in IDLE; in LOCKED advance on transfers and release on tail/MAXLEN.
  always_comb begin
    stateD = stateQ;
    grantD = grantQ;
    selD   = selQ;
    ptrD   = ptrQ;
    cntD   = cntQ;
    errD   = errQ;
    case (stateQ)
      IDLE: begin
        if (rrAny) begin
          stateD = LOCKED;
          grantD = rrGrant;
          selD   = rrIdx;
          cntD   = '0;
        end
      end
      LOCKED: begin
        if (xfer) begin
          if (selTail || (cntQ == LastCnt)) begin
            stateD = IDLE;
            grantD = '0;
            cntD   = '0;
            ptrD   = (selQ == LastIdx) ? '0 : selQ + 1'b1;
            // Released without a tail: the packet was truncated.
            if (!selTail) errD = 1'b1;
          end else begin
            cntD = cntQ + 1'b1;
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      stateQ <= IDLE;
      grantQ <= '0;
      selQ   <= '0;
      ptrQ   <= '0;
      cntQ   <= '0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      grantQ <= grantD;
      selQ   <= selD;
      ptrQ   <= ptrD;
      cntQ   <= cntD;
      errQ   <= errD;
    end
  end

endmodule

// File: tb/tb_packet_arbiter.sv
// Randomized and directed bench for packet_arbiter, checked against a
// packet-level reference model (owner/pointer/flit count per packet).
module tb_packet_arbiter;

  localparam int MaxLen = 16;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] validUp, tailUp, ackUp, peDw;
  logic [1:0] selDw;
  logic       validDw, readyDw, errDw;

  logic valid1, tail1, ack1, pe1, sel1, vdw1, err1;
  logic ready1 = 1'b1;

  int nChecks, nFail;

  // Reference model state.
  bit mLocked;
  int mOwner, mPtr, mFlits;
  bit mErr;
  bit m1Locked;
  int m1Flits;

  always #5 clk = ~clk;

  packet_arbiter #(
    .DIMENSION (4),
    .MAXLEN    (MaxLen)
  ) dut (
    .Clk_i             (clk),
    .Rst_n_i           (rstN),
    .Valid_up_i        (validUp),
    .Tail_up_i         (tailUp),
    .Ack_up_o          (ackUp),
    .PacketEnable_dw_o (peDw),
    .Sel_dw_o          (selDw),
    .Valid_dw_o        (validDw),
    .Ready_dw_i        (readyDw),
    .Error_o           (errDw)
  );

  packet_arbiter #(
    .DIMENSION (1),
    .MAXLEN    (MaxLen)
  ) dutOne (
    .Clk_i             (clk),
    .Rst_n_i           (rstN),
    .Valid_up_i        (valid1),
    .Tail_up_i         (tail1),
    .Ack_up_o          (ack1),
    .PacketEnable_dw_o (pe1),
    .Sel_dw_o          (sel1),
    .Valid_dw_o        (vdw1),
    .Ready_dw_i        (ready1),
    .Error_o           (err1)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mLocked  = 0;
    mOwner   = 0;
    mPtr     = 0;
    mFlits   = 0;
    mErr     = 0;
    m1Locked = 0;
    m1Flits  = 0;
  endtask

  // One clock: apply inputs after the edge, compare mid-cycle, advance model.
  task automatic cycle(input logic [3:0] v, input logic [3:0] t, input logic r);
    logic [3:0] expPe, expAck;
    bit expV, xf, found;
    int p;
    @(posedge clk);
    #1;
    validUp = v;
    tailUp  = t;
    readyDw = r;
    valid1  = 1'b1;
    tail1   = m1Locked && (m1Flits == 1);
    @(negedge clk);
    expPe  = mLocked ? 4'(1 << mOwner) : 4'b0;
    expV   = mLocked && v[mOwner];
    xf     = expV && r;
    expAck = xf ? expPe : 4'b0;
    checkVal("pe", peDw, expPe);
    checkVal("ack", ackUp, expAck);
    checkVal("vdw", validDw, expV);
    checkVal("sel", selDw, mOwner);
    checkVal("err", errDw, mErr);
    checkVal("d1_pe", pe1, m1Locked);
    checkVal("d1_ack", ack1, m1Locked);
    checkVal("d1_vdw", vdw1, m1Locked);
    checkVal("d1_sel", sel1, 0);
    checkVal("d1_err", err1, 0);
    if (!mLocked) begin
      if (v != 4'b0) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          p = (mPtr + k) % 4;
          if (!found && v[p]) begin
            found  = 1;
            mOwner = p;
          end
        end
        mLocked = 1;
        mFlits  = 0;
      end
    end else if (xf) begin
      mFlits++;
      if (t[mOwner] || mFlits == MaxLen) begin
        mLocked = 0;
        mPtr    = (mOwner + 1) % 4;
        if (!t[mOwner]) mErr = 1;
      end
    end
    if (!m1Locked) begin
      m1Locked = 1;
      m1Flits  = 0;
    end else begin
      m1Flits++;
      if (m1Flits == 2) m1Locked = 0;
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic pulseReset();
    @(posedge clk);
    #2;
    rstN    = 1'b0;
    validUp = '0;
    tailUp  = '0;
    readyDw = 1'b0;
    valid1  = 1'b0;
    tail1   = 1'b0;
    #1;
    checkVal("rst_pe", peDw, 0);
    checkVal("rst_ack", ackUp, 0);
    checkVal("rst_vdw", validDw, 0);
    checkVal("rst_sel", selDw, 0);
    checkVal("rst_err", errDw, 0);
    checkVal("rst_d1_pe", pe1, 0);
    modelReset();
    @(negedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    logic [3:0] v, t, expPe;
    logic r;
    nChecks = 0;
    nFail   = 0;
    rstN    = 1'b0;
    validUp = '0;
    tailUp  = '0;
    readyDw = 1'b0;
    valid1  = 1'b0;
    tail1   = 1'b0;
    modelReset();
    #3;
    checkVal("init_pe", peDw, 0);
    checkVal("init_ack", ackUp, 0);
    checkVal("init_vdw", validDw, 0);
    checkVal("init_err", errDw, 0);
    @(negedge clk);
    rstN = 1'b1;

    // 3-flit packet on port 2, then pointer moves to port 3.
    cycle(4'b0100, 4'b0000, 1'b1);
    checkVal("t1_bubble", peDw, 4'b0000);
    cycle(4'b0100, 4'b0000, 1'b1);
    checkVal("t1_grant", peDw, 4'b0100);
    cycle(4'b0100, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0100, 1'b1);
    checkVal("t1_tail_ack", ackUp, 4'b0100);
    cycle(4'b1111, 4'b0000, 1'b0);
    checkVal("t1_idle", peDw, 4'b0000);
    cycle(4'b1111, 4'b0000, 1'b0);
    checkVal("t1_ptr", peDw, 4'b1000);

    // All ports valid, single-flit packets: 0,1,2,3,0 with bubbles.
    pulseReset();
    for (int i = 1; i <= 10; i++) begin
      cycle(4'b1111, 4'b1111, 1'b1);
      expPe = (i % 2 == 1) ? 4'b0000 : 4'(1 << ((i / 2 - 1) % 4));
      checkVal("t2_order", peDw, expPe);
    end

    // Backpressure on port 1 while port 3 requests.
    pulseReset();
    cycle(4'b0010, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1010, 4'b0000, 1'b0);
      checkVal("t3_hold_pe", peDw, 4'b0010);
      checkVal("t3_hold_ack", ackUp, 4'b0000);
    end
    cycle(4'b1010, 4'b0010, 1'b1);
    checkVal("t3_resume", ackUp, 4'b0010);

    // Port 0 exceeds MAXLEN without a tail: forced release, sticky error.
    pulseReset();
    for (int i = 0; i < MaxLen + 2; i++) cycle(4'b0011, 4'b0000, 1'b1);
    checkVal("t4_err", errDw, 1);
    checkVal("t4_released", peDw, 4'b0000);
    cycle(4'b0011, 4'b0000, 1'b1);
    checkVal("t4_next_grant", peDw, 4'b0010);
    checkVal("t4_err_sticky", errDw, 1);
    cycle(4'b0010, 4'b0010, 1'b1);

    // Reset mid-packet on port 2 clears error; arbitration restarts at port 0.
    cycle(4'b0100, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b1);
    checkVal("t5_locked", peDw, 4'b0100);
    pulseReset();
    cycle(4'b1111, 4'b0000, 1'b1);
    cycle(4'b1111, 4'b0000, 1'b1);
    checkVal("t5_restart", peDw, 4'b0001);

    // Random traffic; a middle window carries no tails to force releases.
    for (int i = 0; i < 3000; i++) begin
      v = 4'($urandom);
      t = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      if (i >= 1200 && i < 1900) t = 4'b0000;
      r = ($urandom_range(0, 3) != 0);
      cycle(v, t, r);
      if ($urandom_range(0, 399) == 0) pulseReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
